// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel deserializer.
// One-hot state encodings line up with the upstream PISO stage.
package sipo_pkg;

  localparam int unsigned SIPO_WIDTH = 8;
  localparam int unsigned SIPO_DEPTH = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_SHIFT = 3'b010,
    S_HOLD  = 3'b100
  } state_e;

endpackage

// File: rtl/sipo_fifo.sv
// First-word-fall-through word buffer for the deserializer output.
// Pointers carry an extra wrap bit so full and empty are unambiguous.
module sipo_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_fire, rd_fire;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // A read on the same edge frees the slot a write into a full buffer needs.
  assign rd_fire = rd_en_i && !empty_o;
  assign wr_fire = wr_en_i && (!full_o || rd_fire);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sipo.sv
// Serial-in/parallel-out deserializer: LSB-first bits in, buffered words out.
// state | meaning: S_IDLE no bits held | S_SHIFT partial word | S_HOLD last bit blocked by full buffer
module sipo
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_WIDTH,
  parameter int unsigned DEPTH = SIPO_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             sclk_i,
  input  logic             rst_i,
  input  logic             data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  input  logic             flush_i,
  output logic [AW:0]      level_o,
  output logic [15:0]      byte_cnt_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [LW-1:0] ONE_SHORT = LW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]      byte_cnt_q, byte_cnt_d;
  logic             accept, push, pop;
  logic             fifo_full, fifo_empty;
  logic             full_d, hold_d;

  assign accept     = valid_i && ready_o;
  assign push       = accept && !flush_i && (bit_cnt_q == LAST_BIT);
  assign pop        = valid_o && ready_i;
  assign valid_o    = !fifo_empty;
  assign byte_cnt_o = byte_cnt_q;

  sipo_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i   (sclk_i),
    .rst_i   (rst_i),
    .wr_en_i (push),
    .wdata_i ({data_i, shreg_q[WIDTH-1:1]}),
    .rd_en_i (pop),
    .rdata_o (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    if (flush_i) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
    end else if (accept) begin
      shreg_d   = {data_i, shreg_q[WIDTH-1:1]};
      bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
    end
    if (pop) byte_cnt_d = byte_cnt_q + 16'd1;
  end

  // Buffer fullness after this edge, so the state tracks bit_cnt and level together.
  always_comb begin
    full_d = fifo_full;
    if (push && !pop)      full_d = (level_o == ONE_SHORT);
    else if (pop && !push) full_d = 1'b0;
  end

  assign hold_d = (bit_cnt_d == LAST_BIT) && full_d;

  always_ff @(posedge sclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bit_cnt_d != '0) state_d = hold_d ? S_HOLD : S_SHIFT;
      end
      S_SHIFT: begin
        if (bit_cnt_d == '0) state_d = S_IDLE;
        else if (hold_d)     state_d = S_HOLD;
      end
      S_HOLD: begin
        if (bit_cnt_d == '0) state_d = S_IDLE;
        else if (!full_d)    state_d = S_SHIFT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q != S_HOLD);
  end

endmodule
